// File: rtl/xor_decrypt_receiver.sv
// xor_decrypt_receiver: serial key load, framed ciphertext deserialization and
// repeating-key XOR decryption with a one-cycle plaintext valid pulse.
module xor_decrypt_receiver #(
  parameter int MSG_SIZE = 64,
  parameter int KEY_SIZE = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iSerial_in,
  input  logic                iLoad_key,
  input  logic                iSerial_flag,
  output logic [MSG_SIZE-1:0] oPlaintext,
  output logic                oValid,
  output logic                oKey_ready,
  output logic                oBusy,
  output logic                oError
);
  localparam int MW = $clog2(MSG_SIZE) + 1;
  localparam int KW = $clog2(KEY_SIZE) + 1;
  typedef enum logic [2:0] {IDLE, KEY, RECV, DECRYPT, DRAIN} state_t;
  state_t              r_state;
  logic [KEY_SIZE-1:0] r_key;
  logic [MSG_SIZE-1:0] r_cipher;
  logic [MW-1:0]       r_mcnt;
  logic [KW-1:0]       r_kcnt;
  logic                r_orphan;
  logic [MSG_SIZE-1:0] w_pad;
  logic [MSG_SIZE-1:0] w_cipher_nx;
  logic [KEY_SIZE-1:0] w_key_nx;
  assign w_pad       = {(MSG_SIZE/KEY_SIZE){r_key}};
  assign w_cipher_nx = {r_cipher[MSG_SIZE-2:0], iSerial_in};
  assign w_key_nx    = {r_key[KEY_SIZE-2:0], iSerial_in};
  assign oBusy       = (r_state == RECV) || (r_state == DECRYPT) || (r_state == DRAIN);
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state    <= IDLE;
      r_key      <= '0;
      r_cipher   <= '0;
      r_mcnt     <= '0;
      r_kcnt     <= '0;
      r_orphan   <= 1'b0;
      oPlaintext <= '0;
      oValid     <= 1'b0;
      oKey_ready <= 1'b0;
      oError     <= 1'b0;
    end else if (iEn) begin
      oValid <= 1'b0;
      oError <= 1'b0;
      case (r_state)
        IDLE: begin
          if (iSerial_flag && oKey_ready) begin
            r_cipher <= w_cipher_nx;
            r_mcnt   <= MW'(1);
            r_state  <= RECV;
          end else if (iLoad_key) begin
            r_key      <= w_key_nx;
            r_kcnt     <= KW'(1);
            oKey_ready <= 1'b0;
            r_orphan   <= 1'b0;
            r_state    <= KEY;
          end else if (iSerial_flag) begin
            r_orphan <= 1'b1;
          end else if (r_orphan) begin
            // keyless frame is reported once, when its flag falls
            oError   <= 1'b1;
            r_orphan <= 1'b0;
          end
        end
        KEY: begin
          r_kcnt  <= '0;
          r_state <= IDLE;
          if (!iLoad_key) r_key <= '0;
          else if (r_kcnt == KW'(KEY_SIZE - 1)) begin
            r_key      <= w_key_nx;
            oKey_ready <= 1'b1;
          end else begin
            r_key   <= w_key_nx;
            r_kcnt  <= r_kcnt + KW'(1);
            r_state <= KEY;
          end
        end
        RECV: begin
          r_mcnt <= '0;
          if (!iSerial_flag) begin
            oError  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cipher <= w_cipher_nx;
            if (r_mcnt == MW'(MSG_SIZE - 1)) r_state <= DECRYPT;
            else r_mcnt <= r_mcnt + MW'(1);
          end
        end
        DECRYPT: begin
          oPlaintext <= r_cipher ^ w_pad;
          oValid     <= 1'b1;
          r_state    <= iSerial_flag ? DRAIN : IDLE;
        end
        DRAIN: r_state <= iSerial_flag ? DRAIN : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
